// File: rtl/usb_pkg.sv
// Shared USB full-speed definitions for the packet encoder and decoder.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package usb_pkg;

    // Packet type codes reported on rx_packet and accepted as tx_packet.
    localparam logic [2:0] PKT_NONE  = 3'd0;
    localparam logic [2:0] PKT_DATA0 = 3'd1;
    localparam logic [2:0] PKT_ACK   = 3'd2;
    localparam logic [2:0] PKT_NAK   = 3'd3;
    localparam logic [2:0] PKT_STALL = 3'd4;
    localparam logic [2:0] PKT_IN    = 3'd5;
    localparam logic [2:0] PKT_OUT   = 3'd6;

    // PID bytes as assembled LSB-first from the wire.
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_OUT   = 8'hE1;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_TOKEN,
        ST_DATA,
        ST_HS_EOP,
        ST_DONE,
        ST_ERR,
        ST_EOP_ERR,
        ST_EOP_WAIT
    } rx_state_e;

endpackage

// File: rtl/rx_pid_decode.sv
// PID byte classifier: checks the complement nibble and maps known PIDs to packet codes.
// Latency: combinational.
// Backpressure: none; ports are pid_byte in, pid_valid/pid_code out (code 0 when invalid).
module rx_pid_decode
    import usb_pkg::*;
(
    input  logic [7:0] pid_byte,
    output logic       pid_valid,
    output logic [2:0] pid_code
);

    logic nibble_ok;

    always_comb begin
        nibble_ok = (pid_byte[7:4] == ~pid_byte[3:0]);
        case (pid_byte)
            PID_DATA0: pid_code = PKT_DATA0;
            PID_ACK:   pid_code = PKT_ACK;
            PID_NAK:   pid_code = PKT_NAK;
            PID_STALL: pid_code = PKT_STALL;
            PID_IN:    pid_code = PKT_IN;
            PID_OUT:   pid_code = PKT_OUT;
            default:   pid_code = PKT_NONE;
        endcase
        pid_valid = nibble_ok && (pid_code != PKT_NONE);
        if (!pid_valid) begin
            pid_code = PKT_NONE;
        end
    end

endmodule

// File: rtl/rx_packet_decoder.sv
// USB FS receive framer: checks SYNC/PID/length/EOP, reports packet type, writes DATA0 payload to the FIFO.
// Latency: store strobe 1 cycle after byte_ready; rx_data_ready 2 cycles after EOP is first seen.
// Backpressure: none toward the bus; a byte arriving with the FIFO full is dropped and flagged as an error.
// Ports: clk/n_rst; start_detect, byte_ready+rx_byte, eop_detect, buffer_occupancy in;
//        rx_packet, rx_packet_data+store_rx_packet_data, flush, rx_data_ready, rx_transfer_active, rx_error out.
module rx_packet_decoder
    import usb_pkg::*;
#(
    parameter int MAX_BYTES      = 64,
    parameter int MIN_DATA_BYTES = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start_detect,
    input  logic       byte_ready,
    input  logic [7:0] rx_byte,
    input  logic       eop_detect,
    input  logic [6:0] buffer_occupancy,
    output logic [2:0] rx_packet,
    output logic [7:0] rx_packet_data,
    output logic       store_rx_packet_data,
    output logic       flush,
    output logic       rx_data_ready,
    output logic       rx_transfer_active,
    output logic       rx_error
);

    localparam logic [6:0] MAX_OCC     = 7'(MAX_BYTES);
    localparam logic [6:0] MIN_CNT     = 7'(MIN_DATA_BYTES);
    localparam logic [6:0] TOKEN_BYTES = 7'd2;

    rx_state_e  state_q, state_d;
    logic [6:0] count_q, count_d;
    logic [2:0] rx_packet_q, rx_packet_d;
    logic [7:0] data_q, data_d;
    logic       store_q, store_d;
    logic       flush_q, flush_d;
    logic       ready_q, ready_d;
    logic       error_q, error_d;

    logic       pid_valid;
    logic [2:0] pid_code;
    logic       fifo_full;
    logic [6:0] count_inc;

    rx_pid_decode u_pid_decode (
        .pid_byte  (rx_byte),
        .pid_valid (pid_valid),
        .pid_code  (pid_code)
    );

    always_comb begin
        fifo_full = (buffer_occupancy >= MAX_OCC);
        count_inc = (count_q == 7'h7F) ? count_q : count_q + 7'd1;

        state_d     = state_q;
        count_d     = count_q;
        rx_packet_d = rx_packet_q;
        data_d      = data_q;
        store_d     = 1'b0;
        flush_d     = 1'b0;
        ready_d     = 1'b0;
        error_d     = error_q;

        case (state_q)
            ST_IDLE: begin
                if (start_detect) begin
                    state_d     = ST_SYNC;
                    error_d     = 1'b0;
                    rx_packet_d = PKT_NONE;
                end
            end
            ST_SYNC: begin
                if (byte_ready) begin
                    state_d = (rx_byte == SYNC_BYTE) ? ST_PID : ST_ERR;
                end else if (eop_detect) begin
                    state_d = ST_EOP_ERR;
                end
            end
            ST_PID: begin
                if (byte_ready) begin
                    if (pid_valid) begin
                        rx_packet_d = pid_code;
                        count_d     = '0;
                        case (pid_code)
                            PKT_DATA0: begin
                                state_d = ST_DATA;
                                flush_d = 1'b1;
                            end
                            PKT_IN, PKT_OUT: state_d = ST_TOKEN;
                            default:         state_d = ST_HS_EOP;
                        endcase
                    end else begin
                        rx_packet_d = PKT_NONE;
                        state_d     = ST_ERR;
                    end
                end else if (eop_detect) begin
                    state_d = ST_EOP_ERR;
                end
            end
            ST_TOKEN: begin
                // Address/endpoint/CRC5 content is not needed here, only the byte count.
                if (byte_ready) begin
                    count_d = count_inc;
                    if (count_inc >= TOKEN_BYTES) begin
                        state_d = ST_HS_EOP;
                    end else if (eop_detect) begin
                        state_d = ST_EOP_ERR;
                    end
                end else if (eop_detect) begin
                    state_d = ST_EOP_ERR;
                end
            end
            ST_HS_EOP: begin
                if (byte_ready) begin
                    state_d = ST_ERR;
                end else if (eop_detect) begin
                    state_d = ST_EOP_WAIT;
                end
            end
            ST_DATA: begin
                if (byte_ready && fifo_full) begin
                    state_d = ST_ERR;
                end else begin
                    // A byte landing with EOP is counted before the length check.
                    if (byte_ready) begin
                        data_d  = rx_byte;
                        store_d = 1'b1;
                        count_d = count_inc;
                    end
                    if (eop_detect) begin
                        state_d = (count_d >= MIN_CNT) ? ST_DONE : ST_EOP_ERR;
                    end
                end
            end
            ST_DONE: begin
                ready_d = 1'b1;
                state_d = ST_EOP_WAIT;
            end
            ST_ERR: begin
                error_d = 1'b1;
                if (eop_detect) begin
                    state_d = ST_EOP_WAIT;
                end
            end
            ST_EOP_ERR: begin
                error_d = 1'b1;
                state_d = ST_EOP_WAIT;
            end
            ST_EOP_WAIT: begin
                if (!eop_detect) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            rx_packet_q <= PKT_NONE;
            data_q      <= '0;
            store_q     <= 1'b0;
            flush_q     <= 1'b0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rx_packet_q <= rx_packet_d;
            data_q      <= data_d;
            store_q     <= store_d;
            flush_q     <= flush_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
        end
    end

    assign rx_packet            = rx_packet_q;
    assign rx_packet_data       = data_q;
    assign store_rx_packet_data = store_q;
    assign flush                = flush_q;
    assign rx_data_ready        = ready_q;
    assign rx_error             = error_q;
    assign rx_transfer_active   = (state_q != ST_IDLE);

endmodule

// File: doc/rx_packet_decoder.md
Name: rx_packet_decoder

Overview:
- USB full-speed receive-side packet framer; the receive counterpart of the transmit packet encoder.
- Consumes decoded bytes from the RX shift register/byte counter and validates SYNC, PID and packet length/EOP framing.
- Reports the packet type, pushes DATA0 payload bytes into the shared FIFO, and flags protocol errors to the protocol controller.

Parameters:
- MAX_BYTES, 64, FIFO capacity in bytes. A store attempt at this occupancy is an overflow error.
- MIN_DATA_BYTES, 2, minimum bytes between the PID and EOP for a DATA0 packet (the CRC16 bytes).

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- start_detect  in  1  one-cycle pulse when the bus leaves idle (first K edge)
- byte_ready  in  1  one-cycle pulse; rx_byte valid this cycle (LSB-first assembled)
- rx_byte  in  8  received byte
- eop_detect  in  1  level; high while SE0 is seen on the bus
- buffer_occupancy  in  7  current FIFO fill, 0..MAX_BYTES
- rx_packet  out  3  0 none, 1 DATA0, 2 ACK, 3 NAK, 4 STALL, 5 IN, 6 OUT; registered
- rx_packet_data  out  8  byte presented to the FIFO
- store_rx_packet_data  out  1  one-cycle FIFO write strobe
- flush  out  1  one-cycle FIFO clear pulse
- rx_data_ready  out  1  one-cycle pulse: valid DATA0 packet fully received
- rx_transfer_active  out  1  high while a packet is in progress
- rx_error  out  1  sticky error; cleared on the next start_detect

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE.
  - All outputs are 0, including rx_packet.
  - The byte counter is cleared.
- State machine (registered state; outputs decoded from state/registers, no combinational path from rx_byte to strobes other than rx_packet_data):
  - IDLE:
    - start_detect → SYNC.
    - On the same edge, clear rx_error and set rx_packet=0.
  - SYNC:
    - byte_ready with rx_byte==8'h80 → PID.
    - byte_ready with any other value → ERR.
    - eop_detect → EOP_ERR.
  - PID:
    - On byte_ready, the PID is valid only if rx_byte[7:4]==~rx_byte[3:0] and the byte is one of C3, D2, 5A, 1E, 69, E1.
    - Valid PID: latch rx_packet next cycle.
    - C3 → DATA, with a flush pulse the next cycle and byte count cleared.
    - D2, 5A, 1E → HS_EOP.
    - 69, E1 → TOKEN, with byte count cleared.
    - Invalid PID → ERR, and rx_packet is set to 0.
    - eop_detect → EOP_ERR.
  - TOKEN:
    - Each byte_ready increments the count; address/endpoint/CRC5 bytes are discarded.
    - After the 2nd byte → HS_EOP.
    - eop_detect before 2 bytes → EOP_ERR.
  - HS_EOP:
    - eop_detect → EOP_WAIT, with no rx_data_ready.
    - byte_ready (extra byte) → ERR.
  - DATA:
    - On byte_ready with occupancy<MAX_BYTES: drive rx_packet_data=rx_byte and pulse store the next cycle; count++ (saturating at 127).
    - On byte_ready with occupancy==MAX_BYTES: no store → ERR.
    - On eop_detect with count>=MIN_DATA_BYTES → DONE.
    - On eop_detect with count<MIN_DATA_BYTES → EOP_ERR.
    - If byte_ready and eop_detect occur in the same cycle, the byte is stored and counted first, then EOP is evaluated with the updated count.
  - DONE: one cycle; rx_data_ready=1 → EOP_WAIT.
  - ERR:
    - rx_error set and held.
    - Wait for eop_detect → EOP_WAIT.
    - start_detect is ignored.
  - EOP_ERR:
    - rx_error set → EOP_WAIT.
  - EOP_WAIT:
    - Wait for eop_detect low → IDLE.
- rx_transfer_active is 1 in every state except IDLE.
- start_detect outside IDLE is ignored.
- The CRC value is not checked in this block; it is stored in the FIFO as payload.
- Latency:
  - store strobe is 1 cycle after byte_ready.
  - rx_data_ready is 1 cycle after the DONE entry edge, i.e. 2 cycles after EOP is first seen.

Decomposition:
- Package usb_pkg, shared with the encoder, holds:
  - the rx_packet/tx_packet code constants;
  - the PID byte constants (C3, D2, 5A, 1E, 69, E1);
  - SYNC_BYTE 8'h80;
  - the typedef enum for the decoder states (IDLE, SYNC, PID, TOKEN, DATA, HS_EOP, DONE, ERR, EOP_ERR, EOP_WAIT).
- One natural sub-module, rx_pid_decode: combinational byte→{valid, code[2:0]}, reusable by the tests.

Test Plan:
- DATA0 path: start, 80, C3, 11, 22, A5, 5A, then EOP → flush once; 4 store pulses with data 11, 22, A5, 5A; rx_packet=1; rx_data_ready one pulse; rx_error=0; active returns 0 after EOP drops.
- ACK handshake: start, 80, D2, EOP → rx_packet=2; no store; no rx_data_ready; rx_error=0.
- Bad PID: start, 80, C2 → rx_error=1 and rx_packet=0. After EOP, a new start clears rx_error and the next packet (80, 5A, EOP) gives rx_packet=3.
- Overflow: buffer_occupancy=64 during a DATA0 byte → no store; rx_error=1; FSM waits for EOP, then returns to IDLE.
- Short and early EOP:
  - DATA0 with 1 byte then EOP → rx_error=1, no rx_data_ready.
  - IN token with EOP after 1 byte → rx_error=1.
  - Same-cycle byte_ready+eop after the 1st payload byte → byte stored, count=2, DONE.
- Reset mid-packet: assert n_rst low during DATA → all outputs 0 immediately; after release, a full OUT token (80, E1, xx, xx, EOP) decodes to rx_packet=6.
